// File: rtl/hpdmc_dqsched.sv
// DQ/DQS data-phase scheduler: tracks issued READ/WRITE commands, drives the
// DQ output-enable controls and FML data strobe, and flags when the next command is safe.
module hpdmc_dqsched #(
    parameter int CL    = 3,
    parameter int BURST = 4,
    parameter int TWTR  = 1,
    parameter int TWR   = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic read,
    input  logic write,
    output logic read_safe,
    output logic write_safe,
    output logic precharge_safe,
    output logic direction,
    output logic direction_r,
    output logic data_ack,
    output logic cmd_err
);

    localparam int BH   = BURST / 2;
    localparam int M1   = (BH + TWTR > CL + BH) ? BH + TWTR : CL + BH;
    localparam int MAXL = (M1 > BH + TWR) ? M1 : BH + TWR;
    localparam int CW   = $clog2(MAXL + 1);
    localparam int SRD  = CL + BH;

    localparam logic [CW-1:0] LD_WR_RD  = CW'(BH + TWTR);
    localparam logic [CW-1:0] LD_WR_WR  = CW'(BH - 1);
    localparam logic [CW-1:0] LD_WR_PRE = CW'(BH + TWR);
    localparam logic [CW-1:0] LD_RD_RD  = CW'(BH - 1);
    localparam logic [CW-1:0] LD_RD_WR  = CW'(CL + BH);
    localparam logic [CW-1:0] LD_RD_PRE = CW'(BH - 1);
    localparam logic [CW-1:0] LD_DIR    = CW'(BH);

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
        return (v == '0) ? v : v - CW'(1);
    endfunction

    function automatic logic [CW-1:0] umax(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CW-1:0]  dir_cnt_q, dir_cnt_d;
    logic [SRD-1:0] rdsr_q, rdsr_d;
    logic           direction_q, direction_d;
    logic           direction_r_q;
    logic           data_ack_q, data_ack_d;
    logic           cmd_err_q, cmd_err_d;
    logic           wr_cmd, rd_cmd;

    // A simultaneous read and write is executed as a write only.
    assign wr_cmd = write;
    assign rd_cmd = read & ~write;

    assign read_safe      = (rd_cnt_q == '0);
    assign write_safe     = (wr_cnt_q == '0);
    assign precharge_safe = (pre_cnt_q == '0);
    assign direction      = direction_q;
    assign direction_r    = direction_r_q;
    assign data_ack       = data_ack_q;
    assign cmd_err        = cmd_err_q;

    always_comb begin
        rd_cnt_d  = umax(sat_dec(rd_cnt_q),
                         wr_cmd ? LD_WR_RD  : (rd_cmd ? LD_RD_RD  : '0));
        wr_cnt_d  = umax(sat_dec(wr_cnt_q),
                         wr_cmd ? LD_WR_WR  : (rd_cmd ? LD_RD_WR  : '0));
        pre_cnt_d = umax(sat_dec(pre_cnt_q),
                         wr_cmd ? LD_WR_PRE : (rd_cmd ? LD_RD_PRE : '0));
        dir_cnt_d = umax(sat_dec(dir_cnt_q), wr_cmd ? LD_DIR : '0);
        // Bit k set means a read issued k+1 cycles ago; acks cover k = CL..CL+BH-1.
        rdsr_d      = {rdsr_q[SRD-2:0], rd_cmd};
        direction_d = (dir_cnt_d != '0);
        data_ack_d  = direction_d | (|rdsr_d[SRD-1:CL]);
        cmd_err_d   = cmd_err_q | (read & write) | (read & ~read_safe)
                    | (write & ~write_safe);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            pre_cnt_q     <= '0;
            dir_cnt_q     <= '0;
            rdsr_q        <= '0;
            direction_q   <= 1'b0;
            direction_r_q <= 1'b0;
            data_ack_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            pre_cnt_q     <= pre_cnt_d;
            dir_cnt_q     <= dir_cnt_d;
            rdsr_q        <= rdsr_d;
            direction_q   <= direction_d;
            direction_r_q <= direction_q;
            data_ack_q    <= data_ack_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_hpdmc_dqsched.sv
// Scoreboard bench for hpdmc_dqsched (CL=3, BURST=4, TWTR=1, TWR=2): directed
// commands with hand-computed per-cycle output vectors checked by a monitor.
module tb_hpdmc_dqsched;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic read      = 1'b0;
    logic write     = 1'b0;
    logic read_safe, write_safe, precharge_safe;
    logic direction, direction_r, data_ack, cmd_err;

    hpdmc_dqsched #(.CL(3), .BURST(4), .TWTR(1), .TWR(2)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .read           (read),
        .write          (write),
        .read_safe      (read_safe),
        .write_safe     (write_safe),
        .precharge_safe (precharge_safe),
        .direction      (direction),
        .direction_r    (direction_r),
        .data_ack       (data_ack),
        .cmd_err        (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Vector order: read_safe, write_safe, precharge_safe, direction, direction_r, data_ack, cmd_err
    logic [6:0] obs;
    assign obs = {read_safe, write_safe, precharge_safe, direction, direction_r, data_ack, cmd_err};

    localparam logic [6:0] IDLE = 7'b1110000;

    function automatic logic [6:0] vec(bit rs, bit ws, bit ps, bit d, bit dr, bit da, bit ce);
        return {rs, ws, ps, d, dr, da, ce};
    endfunction

    function automatic bit inw(int c, int a, int b);
        return (c >= a) && (c <= b);
    endfunction

    task automatic check(string nm, int c, logic [6:0] got, logic [6:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s cyc %0d: got %b want %b (rs ws ps dir dir_r ack err)",
                      nm, c, got, want);
    endtask

    task automatic push(string nm, int c, logic [6:0] v);
        exp_t e;
        e.c = c; e.v = v; e.name = nm;
        q.push_back(e);
    endtask

    always @(negedge sys_clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.c < cyc) check({e.name, "_missed"}, e.c, 7'bx, e.v);
            else           check(e.name, e.c, obs, e.v);
        end
    end

    task automatic wait_cyc(int t);
        while (cyc < t) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic cmd(int c, bit r, bit w);
        wait_cyc(c);
        read  = r;
        write = w;
        wait_cyc(c + 1);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_reset(output int b);
        read      = 1'b0;
        write     = 1'b0;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        b = cyc;
    endtask

    task automatic drain(string nm, int last);
        wait_cyc(last + 1);
        #5;
        n_chk++;
        if (q.size() == 0) n_pass++;
        else begin
            $display("FAIL %s_drain: got %0d pending want 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        int b;

        // Reset release and idle
        do_reset(b);
        for (int c = 1; c <= 20; c++) push("idle", b + c, IDLE);
        drain("idle", b + 20);

        // Single write
        do_reset(b);
        for (int c = 10; c <= 16; c++)
            push("write", b + c, vec(!inw(c, 11, 13), !inw(c, 11, 11), !inw(c, 11, 14),
                                     inw(c, 11, 12), inw(c, 12, 13), inw(c, 11, 12), 1'b0));
        cmd(b + 10, 1'b0, 1'b1);
        drain("write", b + 16);

        // Back-to-back reads
        do_reset(b);
        for (int c = 10; c <= 19; c++)
            push("rd_rd", b + c, vec(!(c == 11 || c == 13), !inw(c, 11, 17), !(c == 11 || c == 13),
                                     1'b0, 1'b0, inw(c, 14, 17), 1'b0));
        cmd(b + 10, 1'b1, 1'b0);
        cmd(b + 12, 1'b1, 1'b0);
        drain("rd_rd", b + 19);

        // Write issued while write_safe is low
        do_reset(b);
        for (int c = 10; c <= 22; c++)
            push("rd_wr_err", b + c, vec(!(c == 11 || inw(c, 15, 17)), !inw(c, 11, 15),
                                         !(c == 11 || inw(c, 15, 18)), inw(c, 15, 16),
                                         inw(c, 16, 17), inw(c, 14, 16), c >= 15));
        cmd(b + 10, 1'b1, 1'b0);
        cmd(b + 14, 1'b0, 1'b1);
        drain("rd_wr_err", b + 22);

        // Read and write together: executed as write, error flagged
        do_reset(b);
        for (int c = 10; c <= 16; c++)
            push("rw_both", b + c, vec(!inw(c, 11, 13), !inw(c, 11, 11), !inw(c, 11, 14),
                                       inw(c, 11, 12), inw(c, 12, 13), inw(c, 11, 12), c >= 11));
        cmd(b + 10, 1'b1, 1'b1);
        drain("rw_both", b + 16);

        // Reset asserted mid-burst
        do_reset(b);
        push("rst_pre", b + 11, vec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        for (int c = 12; c <= 20; c++) push("rst_mid", b + c, IDLE);
        cmd(b + 10, 1'b0, 1'b1);
        #5;
        sys_rst_n = 1'b0;
        #1;
        check("rst_async", cyc, obs, IDLE);
        wait_cyc(b + 13);
        #5;
        sys_rst_n = 1'b1;
        drain("rst_mid", b + 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
